alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//   Command front-end for the ALU datapath, directly upstream of the 3-to-8 op decoder.
//   - Buffers ALU commands (opcode + two operands) in a small FIFO.
//   - Issues commands one at a time: drives the 3-bit op select into the decoder and
//     the operands into the ALU, waits ALU_LAT cycles, then captures the result.
//   - Returns each result on a valid/ready response port, strictly in command order.
// PARAMETERS
//   WIDTH    8   operand/result width in bits (>=1)
//   DEPTH    4   command FIFO entries (power of 2, >=2)
//   ALU_LAT  1   cycles op_en is held per command; result sampled on last (>=1)
// PORTS
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous, active-low reset
//   cmd_valid   in   1          command present
//   cmd_ready   out  1          FIFO can accept a command
//   cmd_op      in   3          opcode
//   cmd_a       in   WIDTH      operand A
//   cmd_b       in   WIDTH      operand B
//   op_sel      out  3          opcode to decoder select input
//   op_en       out  1          qualifies decoder one-hot output; high only while issuing
//   opnd_a      out  WIDTH      operand A to ALU
//   opnd_b      out  WIDTH      operand B to ALU
//   alu_result  in   WIDTH      ALU output, sampled on last issue cycle
//   rsp_valid   out  1          response present
//   rsp_ready   in   1          consumer accepts response
//   rsp_data    out  WIDTH      captured ALU result
//   rsp_op      out  3          opcode that produced rsp_data
//   fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   op_count    out  16         completed responses, wraps 16'hFFFF -> 0
// BEHAVIOUR
//   Reset (async, rst_n=0): every output and register is 0, including all FIFO
//     pointers, op_count, state=IDLE, and cmd_ready. Exception: cmd_ready goes to 1
//     on the first edge after rst_n deasserts.
//   Reset mid-operation: FIFO contents, in-flight command and pending response are
//     discarded; no response is produced for them.
//   FIFO:
//     - cmd_ready = (fifo_count < DEPTH), taken from registered state.
//     - Push on cmd_valid && cmd_ready.
//     - When full, a same-cycle pop does NOT allow a push.
//     - Simultaneous push and pop leaves fifo_count unchanged.
//     - Pointers wrap modulo DEPTH.
//   FSM (registered state):
//     IDLE:  if fifo_count != 0, pop the head into the op/operand registers and go to
//            ISSUE with the cycle counter = 0; otherwise stay in IDLE.
//     ISSUE: op_en=1, op_sel=op reg, opnd_a/opnd_b=operand regs. Counter increments
//            each cycle. In the cycle with counter == ALU_LAT-1: capture alu_result
//            into rsp_data, copy op into rsp_op, set rsp_valid, go to RESP.
//     RESP:  hold rsp_valid, rsp_data and rsp_op stable until rsp_ready.
//            On rsp_valid && rsp_ready: clear rsp_valid, increment op_count, go to IDLE.
//   Outside ISSUE: op_en=0 and op_sel=3'b000. opnd_a/opnd_b hold their last values.
//   Timing:
//     - Latency: a command accepted on edge E into an empty FIFO with FSM in IDLE is
//       popped on E+1, and rsp_valid is high after edge E+1+ALU_LAT.
//     - Throughput: at most one command per ALU_LAT+2 cycles (RESP -> IDLE -> pop).
//   Handshake rules:
//     - rsp_valid never drops without rsp_ready.
//     - rsp_ready while rsp_valid=0 has no effect.
//     - cmd_* inputs are ignored when cmd_ready=0.
//   Widths: results pass through unmodified at WIDTH bits; op_count wraps silently.
// TESTING
//   1 Reset then single cmd op=3'b101,a=8'h12,b=8'h34, ALU model a+b, rsp_ready=1 ->
//     op_en high 1 cycle with op_sel=5; rsp_valid after E+2 with rsp_data=8'h46,
//     rsp_op=5; op_count=1.
//   2 Hold rsp_ready=0, push 5 cmds back-to-back ->
//     - cmd_ready=0 once fifo_count=4 with one cmd held in RESP; 6th push refused;
//     - raising rsp_ready drains all 5 in order; op_count=5.
//   3 ALU_LAT=3, op=3'b111 -> op_en high exactly 3 cycles; alu_result sampled on the
//     3rd cycle only (changing it on cycles 1-2 must not affect rsp_data).
//   4 Push and pop on the same edge with fifo_count=2 -> fifo_count stays 2, and
//     ordering is preserved across pointer wrap (>=10 cmds, random rsp_ready).
//   5 Assert rst_n=0 mid-ISSUE with 3 cmds queued -> outputs 0 immediately,
//     fifo_count=0, no stale rsp_valid after release; next cmd behaves as scenario 1.
//   6 Preload op_count=16'hFFFF (via 65535 ops or force) then complete one op ->
//     op_count=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ALU command front-end: buffers opcode/operand commands in a FIFO, issues them one at
// a time to the op decoder and ALU, and returns results in order on a valid/ready port.
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  output logic [2:0]             op_sel,
  output logic                   op_en,
  output logic [WIDTH-1:0]       opnd_a,
  output logic [WIDTH-1:0]       opnd_b,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [2:0]             rsp_op,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            op_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int LCW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;
  state_t           state_q, state_d;
  logic [LCW-1:0]   lat_q, lat_d;
  logic [2:0]       op_sel_q, op_sel_d;
  logic             op_en_q, op_en_d;
  logic [WIDTH-1:0] opnd_a_q, opnd_a_d;
  logic [WIDTH-1:0] opnd_b_q, opnd_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic [15:0]      op_count_q, op_count_d;

  logic push_s;
  logic pop_s;
  cmd_t head_s;

  // cmd_ready is registered, so a full FIFO refuses a push even if it pops this cycle.
  assign push_s = cmd_valid && cmd_ready_q;
  assign pop_s  = (state_q == S_IDLE) && (count_q != CW'(0));
  assign head_s = mem_q[rd_ptr_q];

  // FIFO occupancy and registered ready
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d < CW'(DEPTH));
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Issue FSM next-state and output register values
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    op_sel_d    = op_sel_q;
    op_en_d     = op_en_q;
    opnd_a_d    = opnd_a_q;
    opnd_b_d    = opnd_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          op_sel_d = head_s.op;
          opnd_a_d = head_s.a;
          opnd_b_d = head_s.b;
          op_en_d  = 1'b1;
          lat_d    = '0;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // op_sel_q still holds the opcode here; it is zeroed as the result is captured.
        if (lat_q == LCW'(ALU_LAT - 1)) begin
          rsp_data_d  = alu_result;
          rsp_op_d    = op_sel_q;
          rsp_valid_d = 1'b1;
          op_en_d     = 1'b0;
          op_sel_d    = 3'b000;
          state_d     = S_RESP;
        end else begin
          lat_d = lat_q + LCW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        op_en_d     = 1'b0;
        op_sel_d    = 3'b000;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      op_sel_q    <= 3'b000;
      op_en_q     <= 1'b0;
      opnd_a_q    <= '0;
      opnd_b_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= 3'b000;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      op_sel_q    <= op_sel_d;
      op_en_q     <= op_en_d;
      opnd_a_q    <= opnd_a_d;
      opnd_b_q    <= opnd_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign op_sel     = op_sel_q;
  assign op_en      = op_en_q;
  assign opnd_a     = opnd_a_q;
  assign opnd_b     = opnd_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = rsp_op_q;
  assign fifo_count = count_q;
  assign op_count   = op_count_q;

endmodule
